// File: rtl/transpose_pkg.sv
// Shared definitions for the transpose arbiter and the transpose unit it fronts.
package transpose_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int CNT_W      = 6;

  typedef logic [0:0] src_id_t;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;

  // TDATA width: sample width rounded up to whole bytes.
  function automatic int axis_width(input int value_width);
    return 8 * ((value_width - 1) / 8 + 1);
  endfunction

endpackage

// File: rtl/transpose_arbiter_tag_fifo.sv
// Source-tag FIFO: one entry per block currently owned by the transpose unit.
module tag_fifo
  import transpose_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  src_id_t din,
  input  logic    pop,
  output src_id_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  src_id_t        mem [DEPTH];
  logic    [AW:0] wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra MSB on the pointers tells full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/transpose_arbiter.sv
// Round-robin sharing of one 8x8 transpose unit between two AXI-Stream producers,
// with tag-steered return of each transposed block to its own consumer.
module transpose_arbiter
  import transpose_pkg::*;
#(
  parameter int VALUE_WIDTH     = 17,
  parameter int AXIS_DATA_WIDTH = axis_width(VALUE_WIDTH),
  parameter int TAG_DEPTH       = 4
) (
  input  logic                       i_clk,
  input  logic                       i_aresetn,
  input  logic                       i_s0_axis_TVALID,
  output logic                       o_s0_axis_TREADY,
  input  logic [AXIS_DATA_WIDTH-1:0] i_s0_axis_TDATA,
  input  logic                       i_s0_axis_TLAST,
  input  logic                       i_s1_axis_TVALID,
  output logic                       o_s1_axis_TREADY,
  input  logic [AXIS_DATA_WIDTH-1:0] i_s1_axis_TDATA,
  input  logic                       i_s1_axis_TLAST,
  output logic                       o_t_axis_TVALID,
  input  logic                       i_t_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] o_t_axis_TDATA,
  output logic                       o_t_axis_TLAST,
  input  logic                       i_r_axis_TVALID,
  output logic                       o_r_axis_TREADY,
  input  logic [AXIS_DATA_WIDTH-1:0] i_r_axis_TDATA,
  input  logic                       i_r_axis_TLAST,
  output logic                       o_m0_axis_TVALID,
  input  logic                       i_m0_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] o_m0_axis_TDATA,
  output logic                       o_m0_axis_TLAST,
  output logic                       o_m1_axis_TVALID,
  input  logic                       i_m1_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] o_m1_axis_TDATA,
  output logic                       o_m1_axis_TLAST,
  output logic [1:0]                 o_err,
  output logic                       o_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

  arb_state_t                            state, state_nxt;
  src_id_t                               last_grant, grant_id, push_id, head;
  logic [CNT_W-1:0]                      in_cnt, out_cnt;
  logic [1:0]                            s_valid, s_last, m_ready;
  logic [1:0][AXIS_DATA_WIDTH-1:0]       s_data;
  logic                                  granted, push, pop, full, empty;
  logic                                  t_hs, r_hs, in_end, out_end;

  assign s_valid  = {i_s1_axis_TVALID, i_s0_axis_TVALID};
  assign s_last   = {i_s1_axis_TLAST,  i_s0_axis_TLAST};
  assign s_data   = {i_s1_axis_TDATA,  i_s0_axis_TDATA};
  assign m_ready  = {i_m1_axis_TREADY, i_m0_axis_TREADY};

  assign granted  = (state != IDLE);
  assign grant_id = src_id_t'(state == GRANT1);
  assign in_end   = (in_cnt == CNT_LAST);
  assign out_end  = (out_cnt == CNT_LAST);
  assign o_busy   = granted || !empty;

  // Grant a whole block; when both wait, the source not granted last wins.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_id   = '0;
    case (state)
      IDLE: begin
        if (!full && |s_valid) begin
          push      = 1'b1;
          push_id   = (s_valid == 2'b11) ? ~last_grant : src_id_t'(s_valid[1]);
          state_nxt = (push_id == 1'b1) ? GRANT1 : GRANT0;
        end
      end
      GRANT0, GRANT1: if (t_hs && in_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_t_axis_TVALID  = 1'b0;
    o_t_axis_TDATA   = '0;
    o_t_axis_TLAST   = 1'b0;
    o_s0_axis_TREADY = 1'b0;
    o_s1_axis_TREADY = 1'b0;
    if (granted) begin
      o_t_axis_TVALID = s_valid[grant_id];
      o_t_axis_TDATA  = s_data[grant_id];
      o_t_axis_TLAST  = in_end;
      if (grant_id == 1'b1) o_s1_axis_TREADY = i_t_axis_TREADY;
      else                  o_s0_axis_TREADY = i_t_axis_TREADY;
    end
  end

  assign t_hs = o_t_axis_TVALID && i_t_axis_TREADY;

  // Return steering; with no tag queued the return stream is stalled.
  always_comb begin
    o_r_axis_TREADY  = 1'b0;
    o_m0_axis_TVALID = 1'b0;
    o_m0_axis_TDATA  = '0;
    o_m0_axis_TLAST  = 1'b0;
    o_m1_axis_TVALID = 1'b0;
    o_m1_axis_TDATA  = '0;
    o_m1_axis_TLAST  = 1'b0;
    if (!empty) begin
      o_r_axis_TREADY = m_ready[head];
      if (head == 1'b1) begin
        o_m1_axis_TVALID = i_r_axis_TVALID;
        o_m1_axis_TDATA  = i_r_axis_TDATA;
        o_m1_axis_TLAST  = i_r_axis_TLAST;
      end else begin
        o_m0_axis_TVALID = i_r_axis_TVALID;
        o_m0_axis_TDATA  = i_r_axis_TDATA;
        o_m0_axis_TLAST  = i_r_axis_TLAST;
      end
    end
  end

  assign r_hs = i_r_axis_TVALID && o_r_axis_TREADY;
  assign pop  = r_hs && out_end;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
      o_err      <= '0;
    end else begin
      state <= state_nxt;
      if (push) last_grant <= push_id;
      // Counters wrap at the block size by their width.
      if (t_hs) in_cnt  <= in_cnt + 1'b1;
      if (r_hs) out_cnt <= out_cnt + 1'b1;
      if (t_hs && (s_last[grant_id] != in_end)) o_err[0] <= 1'b1;
      if ((r_hs && (i_r_axis_TLAST != out_end)) || (empty && i_r_axis_TVALID))
        o_err[1] <= 1'b1;
    end
  end

  tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk   (i_clk),
    .rst_n (i_aresetn),
    .push  (push),
    .din   (push_id),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_transpose_arbiter.sv
// Scoreboard bench: producer queues, a behavioural transpose unit, and consumer monitors.
module tb_transpose_arbiter;
  import transpose_pkg::*;

  localparam int VW = 17;
  localparam int DW = axis_width(VW);
  localparam int TD = 4;

  typedef logic [DW-1:0] dat_t;
  typedef struct packed { dat_t data; logic last; } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0_valid = 0, s0_ready, s0_last = 0, s1_valid = 0, s1_ready, s1_last = 0;
  dat_t       s0_data = '0, s1_data = '0, t_data, r_data = '0, m0_data, m1_data;
  logic       t_valid, t_ready = 1'b1, t_last, r_valid = 0, r_ready, r_last = 0;
  logic       m0_valid, m0_ready, m0_last, m1_valid, m1_ready, m1_last;
  logic [1:0] err;
  logic       busy;

  always #5 clk = ~clk;

  transpose_arbiter #(.VALUE_WIDTH(VW), .AXIS_DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .i_clk(clk), .i_aresetn(rst_n),
    .i_s0_axis_TVALID(s0_valid), .o_s0_axis_TREADY(s0_ready),
    .i_s0_axis_TDATA(s0_data), .i_s0_axis_TLAST(s0_last),
    .i_s1_axis_TVALID(s1_valid), .o_s1_axis_TREADY(s1_ready),
    .i_s1_axis_TDATA(s1_data), .i_s1_axis_TLAST(s1_last),
    .o_t_axis_TVALID(t_valid), .i_t_axis_TREADY(t_ready),
    .o_t_axis_TDATA(t_data), .o_t_axis_TLAST(t_last),
    .i_r_axis_TVALID(r_valid), .o_r_axis_TREADY(r_ready),
    .i_r_axis_TDATA(r_data), .i_r_axis_TLAST(r_last),
    .o_m0_axis_TVALID(m0_valid), .i_m0_axis_TREADY(m0_ready),
    .o_m0_axis_TDATA(m0_data), .o_m0_axis_TLAST(m0_last),
    .o_m1_axis_TVALID(m1_valid), .i_m1_axis_TREADY(m1_ready),
    .o_m1_axis_TDATA(m1_data), .o_m1_axis_TLAST(m1_last),
    .o_err(err), .o_busy(busy)
  );

  int    checks = 0, errors = 0, cyc = 0;
  beat_t sq0[$], sq1[$], exp0[$], exp1[$];
  dat_t  rq[$], tfirst[$], tbuf[64];
  int    tstart_cyc[$], tend_cyc[$], m0_pop_cyc[$];
  int    tin_cnt = 0, rpos = 0, nblk_in = 0, m0_cnt = 0, m1_cnt = 0;
  logic  tog_mode = 1'b0;
  int    ord[4] = '{1, 101, 1, 101};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Queue one 64-beat block and its expected transposed return.
  task automatic send_block(input int src, input int base, input int step, input int extra_last);
    dat_t  v[64];
    beat_t b;
    for (int i = 0; i < 64; i++) v[i] = dat_t'(base + step * i);
    for (int i = 0; i < 64; i++) begin
      b.data = v[i];
      b.last = (i == 63) || (i == extra_last);
      if (src == 0) sq0.push_back(b); else sq1.push_back(b);
    end
    for (int j = 0; j < 64; j++) begin
      b.data = v[(j % 8) * 8 + j / 8];
      b.last = (j == 63);
      if (src == 0) exp0.push_back(b); else exp1.push_back(b);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sq0.size() + sq1.size() + exp0.size() + exp1.size() + rq.size()) != 0 || busy) begin
      @(posedge clk); #1;
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL %s: timeout, pending exp0=%0d exp1=%0d src0=%0d src1=%0d",
                 name, exp0.size(), exp1.size(), sq0.size(), sq1.size());
        sq0.delete(); sq1.delete(); exp0.delete(); exp1.delete();
        return;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Producers: decide handshakes at negedge, present the next beat after posedge.
  initial forever begin
    @(negedge clk);
    if (s0_valid && s0_ready && sq0.size() > 0) void'(sq0.pop_front());
    if (s1_valid && s1_ready && sq1.size() > 0) void'(sq1.pop_front());
    @(posedge clk); #1;
    s0_valid = (sq0.size() > 0);
    s0_data  = s0_valid ? sq0[0].data : '0;
    s0_last  = s0_valid ? sq0[0].last : 1'b0;
    s1_valid = (sq1.size() > 0);
    s1_data  = s1_valid ? sq1[0].data : '0;
    s1_last  = s1_valid ? sq1[0].last : 1'b0;
  end

  // Behavioural transpose unit; shares reset with the arbiter.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      tin_cnt = 0;
      rpos    = 0;
      rq.delete();
    end else begin
      if (t_valid && t_ready) begin
        chk("t_tlast", t_last, tin_cnt == 63);
        if (tin_cnt == 0) begin
          tstart_cyc.push_back(cyc);
          tfirst.push_back(t_data);
        end
        tbuf[tin_cnt] = t_data;
        tin_cnt++;
        if (tin_cnt == 64) begin
          for (int j = 0; j < 64; j++) rq.push_back(tbuf[(j % 8) * 8 + j / 8]);
          tin_cnt = 0;
          nblk_in++;
          tend_cyc.push_back(cyc);
        end
      end
      if (r_valid && r_ready && rq.size() > 0) begin
        void'(rq.pop_front());
        rpos = (rpos + 1) % 64;
      end
    end
    @(posedge clk); #1;
    if (rst_n && rq.size() > 0) begin
      r_valid = 1'b1;
      r_data  = rq[0];
      r_last  = (rpos == 63);
    end else begin
      r_valid = 1'b0;
      r_data  = '0;
      r_last  = 1'b0;
    end
    t_ready = tog_mode ? ~t_ready : 1'b1;
  end

  // Consumer monitors pop the scoreboard on every handshake.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n && m0_valid && m0_ready) begin
      if (exp0.size() == 0) begin
        checks++; errors++;
        $display("FAIL m0_unexpected: got %0h expected no beat", m0_data);
      end else begin
        e = exp0.pop_front();
        chk("m0_data", m0_data, e.data);
        chk("m0_last", m0_last, e.last);
      end
      if (m0_cnt % 64 == 63) m0_pop_cyc.push_back(cyc);
      m0_cnt++;
    end
    if (rst_n && m1_valid && m1_ready) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL m1_unexpected: got %0h expected no beat", m1_data);
      end else begin
        e = exp1.pop_front();
        chk("m1_data", m1_data, e.data);
        chk("m1_last", m1_last, e.last);
      end
      m1_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nb0, c0, c1;
    rst_n = 1'b0; m0_ready = 1'b1; m1_ready = 1'b1;

    // Both producers loaded before reset is released.
    send_block(0, 1, 1, -1);   send_block(0, 1, 1, -1);
    send_block(1, 101, 1, -1); send_block(1, 101, 1, -1);
    repeat (3) @(negedge clk);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_t_valid", t_valid, 0);
    chk("rst_t_data", t_data, 0);
    chk("rst_t_last", t_last, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_m_valid", {m0_valid, m1_valid}, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle("two_src");
    chk("order_n", tfirst.size(), 4);
    for (int k = 0; k < tfirst.size() && k < 4; k++) chk("grant_order", tfirst[k], ord[k]);
    if (tstart_cyc.size() > 1 && tend_cyc.size() > 0)
      chk("block_gap", tstart_cyc[1] - tend_cyc[0], 2);
    chk("two_src_err", err, 0);

    // Single producer, negative samples.
    send_block(0, -1, -1, -1);
    wait_idle("s0_only");
    chk("s0_only_err", err, 0);

    // Throttled transpose input and a consumer stall mid-block.
    tog_mode = 1'b1;
    c0 = m1_cnt;
    send_block(1, 201, 1, -1);
    n = 0;
    while (m1_cnt < c0 + 20 && n < 3000) begin @(posedge clk); #1; n++; end
    m1_ready = 1'b0;
    c1 = m1_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("m1_stall_hold", m1_cnt, c1);
    m1_ready = 1'b1;
    wait_idle("throttle");
    tog_mode = 1'b0;
    chk("m1_beats", m1_cnt - c0, 64);
    chk("throttle_err", err, 0);

    // Early source TLAST on beat 10.
    send_block(0, 301, 1, 9);
    wait_idle("early_tlast");
    chk("early_tlast_err", err, 2'b01);
    send_block(1, 501, 1, -1);
    wait_idle("sticky");
    chk("err_sticky", err, 2'b01);

    // Five blocks against a stalled return side.
    tstart_cyc.delete(); m0_pop_cyc.delete();
    nb0 = nblk_in;
    m0_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_block(0, 1000 * (k + 1), 1, -1);
    n = 0;
    while (nblk_in < nb0 + 4 && n < 2000) begin @(posedge clk); #1; n++; end
    repeat (50) @(posedge clk);
    #1;
    chk("full_blocks_in", nblk_in - nb0, 4);
    chk("full_s0_ready", s0_ready, 0);
    chk("full_t_valid", t_valid, 0);
    chk("full_busy", busy, 1);
    m0_ready = 1'b1;
    wait_idle("fifo_full");
    chk("full_starts", tstart_cyc.size(), 5);
    if (tstart_cyc.size() == 5 && m0_pop_cyc.size() > 0)
      chk("fifth_after_pop", tstart_cyc[4] > m0_pop_cyc[0], 1);

    // Reset in the middle of a block, then a clean block.
    send_block(0, 1, 1, -1);
    n = 0;
    while (tin_cnt < 30 && n < 2000) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    sq0.delete(); sq1.delete(); exp0.delete(); exp1.delete();
    @(negedge clk);
    chk("mid_rst_t_valid", t_valid, 0);
    chk("mid_rst_s0_ready", s0_ready, 0);
    chk("mid_rst_r_ready", r_ready, 0);
    chk("mid_rst_m_valid", {m0_valid, m1_valid}, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_block(0, 1, 1, -1);
    wait_idle("after_reset");
    chk("after_reset_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
